score_display: RTL

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 29 ++
 rtl/score_display.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared types and constants for the two-digit score display.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_BLINK   = 2'd2
    } state_t;

    // Active-low seven-segment codes, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Largest score that fits in two decimal digits.
    localparam logic [6:0] SCORE_MAX = 7'd99;

    // Index of the last shift step of the 7-bit conversion.
    localparam logic [2:0] CONV_LAST = 3'd6;

    function automatic logic [6:0] clamp_score(input logic [6:0] value);
        return (value > SCORE_MAX) ? SCORE_MAX : value;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes go dark.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
    import score_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Straight lookup of the segment pattern for one digit.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Two-digit score display: clamps to 99, converts to BCD serially, then blinks the new value.
// Latency: new digits appear 7 cycles after acceptance; blink runs BLINK_TOGGLES*BLINK_PERIOD cycles.
// Backpressure: in_ready low only while converting; a new score may interrupt the blink.
module score_display
    import score_display_pkg::*;
#(
    parameter int BLINK_PERIOD  = 4,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [6:0] in_value,
    output logic       in_ready,
    output logic       busy,
    output logic [6:0] hex0,
    output logic [6:0] hex1
);

    localparam int PW = (BLINK_PERIOD  > 1) ? $clog2(BLINK_PERIOD)  : 1;
    localparam int TW = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;
    localparam logic [PW-1:0] PHASE_LAST  = PW'(BLINK_PERIOD - 1);
    localparam logic [TW-1:0] TOGGLE_LAST = TW'(BLINK_TOGGLES - 1);

    state_t          state_q,  state_d;
    logic [6:0]      bin_q,    bin_d;     // binary bits still to be shifted in, MSB first
    logic [6:0]      bcd_q,    bcd_d;     // partial BCD: [6:4] tens, [3:0] ones
    logic [2:0]      cnt_q,    cnt_d;
    logic [3:0]      ones_q,   ones_d;
    logic [3:0]      tens_q,   tens_d;
    logic [PW-1:0]   phase_q,  phase_d;   // cycle within the current blink phase
    logic [TW-1:0]   toggle_q, toggle_d;  // blink phase index; odd phases are blanked

    logic            accept;
    logic [3:0]      ones_adj;
    logic [3:0]      tens_new;
    logic [3:0]      ones_new;
    logic            blank;
    logic [6:0]      seg_ones;
    logic [6:0]      seg_tens;

    assign in_ready = (state_q != ST_CONVERT);
    assign busy     = (state_q != ST_IDLE);
    assign accept   = in_valid && in_ready;

    // Next-state, shift-add-3 step and blink timing.
    // With the input clamped to 99 the tens digit is at most 4 before every shift,
    // so it never needs the +3 correction and three bits hold it between steps;
    // the full 4-bit tens value only exists on the final step, where it is loaded.
    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        phase_d  = phase_q;
        toggle_d = toggle_q;

        ones_adj = (bcd_q[3:0] >= 4'd5) ? (bcd_q[3:0] + 4'd3) : bcd_q[3:0];
        tens_new = {bcd_q[6:4], ones_adj[3]};
        ones_new = {ones_adj[2:0], bin_q[6]};

        case (state_q)
            ST_CONVERT: begin
                bin_d = {bin_q[5:0], 1'b0};
                bcd_d = {tens_new[2:0], ones_new};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CONV_LAST) begin
                    ones_d   = ones_new;
                    tens_d   = tens_new;
                    phase_d  = '0;
                    toggle_d = '0;
                    state_d  = (BLINK_TOGGLES == 0) ? ST_IDLE : ST_BLINK;
                end
            end
            ST_BLINK: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (toggle_q == TOGGLE_LAST) begin
                        toggle_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        toggle_d = toggle_q + TW'(1);
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: ;
        endcase

        // A new score wins over anything else, including an unfinished blink.
        if (accept) begin
            state_d = ST_CONVERT;
            bin_d   = clamp_score(in_value);
            bcd_d   = '0;
            cnt_d   = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ones_q   <= '0;
            tens_q   <= '0;
            phase_q  <= '0;
            toggle_q <= '0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            phase_q  <= phase_d;
            toggle_q <= toggle_d;
        end
    end

    seg7_decode u_seg_ones (
        .digit (ones_q),
        .seg   (seg_ones)
    );

    seg7_decode u_seg_tens (
        .digit (tens_q),
        .seg   (seg_tens)
    );

    // Outputs come only from registers: blanking, then leading-zero suppression.
    always_comb begin
        blank = (state_q == ST_BLINK) && toggle_q[0];
        hex0  = blank ? SEG_BLANK : seg_ones;
        hex1  = (blank || (tens_q == 4'd0)) ? SEG_BLANK : seg_tens;
    end

endmodule
